// File: rtl/logic_unit_pipe.sv
// Registered WIDTH-bit bitwise logic unit with accumulate mode and a single
// valid/ready output stage.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_parity,
  output logic [CNT_W-1:0] op_count
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] operand_b;
  logic             valid_q;
  logic             zero_q;
  logic             parity_q;
  logic [CNT_W-1:0] count_q;
  logic             accept;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Accumulator is read pre-update, so chained in_acc ops work at full rate.
  always_comb begin
    operand_b = in_acc ? acc_q : in_b;
    result_d  = '0;
    unique case (in_op)
      3'b000: result_d = ~in_a;
      3'b001: result_d = in_a & operand_b;
      3'b010: result_d = in_a | operand_b;
      3'b011: result_d = in_a ^ operand_b;
      3'b100: result_d = ~(in_a & operand_b);
      3'b101: result_d = ~(in_a | operand_b);
      3'b110: result_d = ~(in_a ^ operand_b);
      3'b111: result_d = in_a;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      parity_q <= 1'b0;
      acc_q    <= '0;
      count_q  <= '0;
    end else if (accept) begin
      valid_q  <= 1'b1;
      result_q <= result_d;
      zero_q   <= ~|result_d;
      parity_q <= ^result_d;
      acc_q    <= result_d;
      count_q  <= count_q + CNT_W'(1);
    end else if (out_ready) begin
      // Transfer without a new accept: result and flags hold their last value.
      valid_q  <= 1'b0;
    end
  end

  assign out_valid  = valid_q;
  assign out_result = result_q;
  assign out_zero   = zero_q;
  assign out_parity = parity_q;
  assign op_count   = count_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: an 8-bit and a 4-bit instance share stimulus; since the
// ops are lane-independent the 4-bit results are the low nibble of one 8-bit model.
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_acc = 1'b0;
  logic [2:0] in_op = 3'd0;
  logic [7:0] in_a = 8'd0;
  logic [7:0] in_b = 8'd0;

  logic       rdy8, v8, z8, p8;
  logic [7:0] r8, c8;
  logic       rdy4, v4, z4, p4;
  logic [3:0] r4;
  logic [1:0] c4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8), .in_op(in_op),
    .in_acc(in_acc), .in_a(in_a), .in_b(in_b), .out_valid(v8), .out_ready(out_ready),
    .out_result(r8), .out_zero(z8), .out_parity(p8), .op_count(c8)
  );

  logic_unit_pipe #(.WIDTH(4), .CNT_W(2)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .in_op(in_op),
    .in_acc(in_acc), .in_a(in_a[3:0]), .in_b(in_b[3:0]), .out_valid(v4),
    .out_ready(out_ready), .out_result(r4), .out_zero(z4), .out_parity(p4), .op_count(c4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] op_fn(input logic [2:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    case (op)
      3'd0:    return ~a;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return a ^ b;
      3'd4:    return ~(a & b);
      3'd5:    return ~(a | b);
      3'd6:    return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  // Behavioural model: one pending result slot, an accumulator and an integer counter.
  bit         m_valid = 1'b0;
  logic [7:0] m_res = 8'd0;
  logic [7:0] m_acc = 8'd0;
  int         m_cnt = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0;
      m_res   = 8'd0;
      m_acc   = 8'd0;
      m_cnt   = 0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_res   = op_fn(in_op, in_a, in_acc ? m_acc : in_b);
      m_acc   = m_res;
      m_cnt   = m_cnt + 1;
      m_valid = 1'b1;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    check("in_ready8", 32'(rdy8), 32'(!m_valid || out_ready));
    check("in_ready4", 32'(rdy4), 32'(!m_valid || out_ready));
    check("out_valid8", 32'(v8), 32'(m_valid));
    check("out_valid4", 32'(v4), 32'(m_valid));
    check("result8", 32'(r8), 32'(m_res));
    check("result4", 32'(r4), 32'(m_res[3:0]));
    check("zero8", 32'(z8), 32'(m_res == 8'd0));
    check("zero4", 32'(z4), 32'(m_res[3:0] == 4'd0));
    check("parity8", 32'(p8), 32'(^m_res));
    check("parity4", 32'(p4), 32'(^m_res[3:0]));
    check("count8", 32'(c8), 32'(m_cnt % 256));
    check("count4", 32'(c4), 32'(m_cnt % 4));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  logic [7:0] all_ops [8];
  logic [3:0] chain_res [3];
  logic       chain_par [3];

  initial begin
    all_ops = '{8'h0F, 8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'hF0};
    chain_res = '{4'hA, 4'h5, 4'h4};
    chain_par = '{1'b0, 1'b0, 1'b1};
    #12;
    rst = 1'b0;
    check("reset_zero", 32'(z8), 32'd1);
    check("reset_valid", 32'(v8), 32'd0);
    check("reset_ready", 32'(rdy8), 32'd1);

    // NOT on the 4-bit lane
    out_ready = 1'b1; in_valid = 1'b1; in_op = 3'd0; in_a = 8'h09;
    step();
    check("not1_r4", 32'(r4), 32'h6);
    check("not1_r8", 32'(r8), 32'hF6);
    check("not1_flags", {z4, p4, v4}, 32'b001);
    check("not1_cnt", 32'(c4), 32'd1);
    in_a = 8'h06;
    step();
    check("not2_r4", 32'(r4), 32'h9);

    // All eight ops back to back
    do_reset();
    in_a = 8'hF0; in_b = 8'h3C; in_acc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_op = 3'(i);
      step();
      check("allops_r8", 32'(r8), 32'(all_ops[i]));
      check("allops_rdy", 32'(rdy8), 32'd1);
    end
    check("allops_cnt", 32'(c8), 32'd8);

    // Accumulate chain: PASS, XOR acc, AND acc
    do_reset();
    in_b = 8'hFF;
    in_op = 3'd7; in_acc = 1'b0; in_a = 8'h0A;
    step();
    check("chain_r4", 32'(r4), 32'(chain_res[0]));
    check("chain_p4", 32'(p4), 32'(chain_par[0]));
    in_op = 3'd3; in_acc = 1'b1; in_a = 8'h0F;
    step();
    check("chain_r4", 32'(r4), 32'(chain_res[1]));
    check("chain_p4", 32'(p4), 32'(chain_par[1]));
    in_op = 3'd1; in_a = 8'h06;
    step();
    check("chain_r4", 32'(r4), 32'(chain_res[2]));
    check("chain_p4", 32'(p4), 32'(chain_par[2]));
    check("chain_z4", 32'(z4), 32'd0);

    // Backpressure holds result, counter and accumulator
    do_reset();
    in_op = 3'd7; in_acc = 1'b0; in_a = 8'h5A;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_a = ~in_a;
      step();
      check("bp_rdy", 32'(rdy8), 32'd0);
      check("bp_hold", 32'(r8), 32'h5A);
      check("bp_cnt", 32'(c8), 32'd1);
    end
    out_ready = 1'b1; in_op = 3'd3; in_acc = 1'b1; in_a = 8'hFF;
    step();
    check("bp_release_r8", 32'(r8), 32'hA5);
    check("bp_release_v", 32'(v8), 32'd1);
    check("bp_release_cnt", 32'(c8), 32'd2);

    // Counter wrap on the 2-bit counter, then zero flag
    do_reset();
    in_op = 3'd7; in_acc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_a = 8'(i + 1);
      step();
      check("wrap_cnt", 32'(c4), 32'((i + 1) % 4));
    end
    in_op = 3'd3; in_a = 8'h0F; in_b = 8'h0F;
    step();
    check("zero_r4", 32'(r4), 32'd0);
    check("zero_z4", 32'(z4), 32'd1);

    // Async reset between edges
    do_reset();
    in_op = 3'd7; in_acc = 1'b0; in_a = 8'h3C;
    step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(v8), 32'd0);
    check("arst_r8", 32'(r8), 32'd0);
    check("arst_cnt", 32'(c8), 32'd0);
    check("arst_zero", 32'(z8), 32'd1);
    rst = 1'b0;
    in_valid = 1'b1; in_op = 3'd3; in_acc = 1'b1; in_a = 8'h03;
    step();
    check("arst_after_r8", 32'(r8), 32'h03);

    // Randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_op     = 3'($urandom_range(0, 7));
      in_acc    = $urandom_range(0, 1) == 1;
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
      step();
    end

    in_valid = 1'b0;
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
